// File: rtl/multichannel_decimator.sv
// Multi-channel decimate-by-R stage: pick or accumulate-and-dump over frames of R samples,
// with run-time ratio/mode latched at frame start and a registered valid/ready output.
module multichannel_decimator #(
  parameter int unsigned W   = 16,
  parameter int unsigned NCH = 2,
  parameter int unsigned RW  = 8,
  parameter int unsigned OW  = W + RW
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_ce,
  input  logic [NCH*W-1:0]    i_data,
  input  logic [RW-1:0]       i_ratio,
  input  logic                i_mode,
  input  logic                i_flush,
  input  logic                i_clr_ovr,
  output logic [NCH*OW-1:0]   o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_overrun,
  output logic [RW-1:0]       o_ratio
);

  logic [RW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     rf_q, rf_d;
  logic              mf_q, mf_d;
  logic [NCH*OW-1:0] acc_q, acc_d;
  logic [NCH*OW-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              frame_start;
  logic [RW-1:0]     ratio_req;
  logic [RW-1:0]     ratio_cur;
  logic              mode_cur;
  logic              take;
  logic              last;
  logic [NCH*OW-1:0] sum;
  logic [OW-1:0]     ext;
  logic [OW-1:0]     acc_ch;

  // Ratio and mode are taken from the inputs only on the frame-start sample.
  always_comb begin
    frame_start = (cnt_q == '0);
    ratio_req   = (i_ratio == '0) ? RW'(1) : i_ratio;
    ratio_cur   = frame_start ? ratio_req : rf_q;
    mode_cur    = frame_start ? i_mode : mf_q;
    take        = i_ce & ~i_flush;
    last        = take && (cnt_q == ratio_cur - RW'(1));
  end

  always_comb begin
    sum    = '0;
    ext    = '0;
    acc_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      ext    = {{(OW-W){i_data[k*W+W-1]}}, i_data[k*W +: W]};
      acc_ch = acc_q[k*OW +: OW];
      sum[k*OW +: OW] = (mode_cur && !frame_start) ? acc_ch + ext : ext;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    rf_d  = rf_q;
    mf_d  = mf_q;
    if (i_flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (i_ce) begin
      if (frame_start) begin
        rf_d = ratio_cur;
        mf_d = mode_cur;
      end
      acc_d = sum;
      cnt_d = last ? '0 : cnt_q + RW'(1);
    end
  end

  // A handshake frees the register; a new result on a still-held one is an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~i_ready;
    ovr_d   = ovr_q & ~i_clr_ovr;
    if (last) begin
      data_d  = sum;
      valid_d = 1'b1;
      if (valid_q && !i_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      rf_q    <= RW'(1);
      mf_q    <= 1'b0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
      mf_q    <= mf_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;
  assign o_ratio   = rf_q;

endmodule

// File: tb/tb_multichannel_decimator.sv
// Directed bench for multichannel_decimator: reset, pick/accumulate, ratio 0/1,
// backpressure/overrun, mid-frame ratio change, flush and async reset restart.
module tb_multichannel_decimator;
  localparam int unsigned W   = 16;
  localparam int unsigned NCH = 2;
  localparam int unsigned RW  = 8;
  localparam int unsigned OW  = W + RW;

  logic              clk;
  logic              rst_n;
  logic              ce;
  logic [NCH*W-1:0]  din;
  logic [RW-1:0]     ratio;
  logic              mode;
  logic              flush;
  logic              clr_ovr;
  logic [NCH*OW-1:0] dout;
  logic              valid;
  logic              ready;
  logic              ovr;
  logic [RW-1:0]     ratio_o;

  int vectors = 0;
  int errors  = 0;

  multichannel_decimator #(.W(W), .NCH(NCH), .RW(RW), .OW(OW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_ce      (ce),
    .i_data    (din),
    .i_ratio   (ratio),
    .i_mode    (mode),
    .i_flush   (flush),
    .i_clr_ovr (clr_ovr),
    .o_data    (dout),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_overrun (ovr),
    .o_ratio   (ratio_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ch0();
    return int'($signed(dout[OW-1:0]));
  endfunction

  function automatic int ch1();
    return int'($signed(dout[2*OW-1:OW]));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted sample on both channels; outputs are checked after the edge.
  task automatic smp(input int a, input int b);
    ce  = 1'b1;
    din = {16'(b), 16'(a)};
    tick();
    ce  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; din = '0; ratio = 8'd1; mode = 1'b0;
    flush = 1'b0; clr_ovr = 1'b0; ready = 1'b1;

    for (int i = 0; i < 4; i++) begin
      ce = 1'($urandom); din = 32'($urandom); ratio = 8'($urandom); mode = 1'($urandom);
      ready = 1'($urandom); clr_ovr = 1'($urandom);
      tick();
    end
    check("rst_data0", ch0(), 0);
    check("rst_data1", ch1(), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_ratio", int'(ratio_o), 1);
    ce = 1'b0; din = '0; mode = 1'b0; ready = 1'b1; clr_ovr = 1'b0; ratio = 8'd4;
    rst_n = 1'b1;
    tick(); tick();
    check("rel_valid", int'(valid), 0);
    check("rel_ratio", int'(ratio_o), 1);
    check("rel_data0", ch0(), 0);

    // Pick mode, R=4
    smp(1, -1); smp(2, -2);
    check("pick_ratio", int'(ratio_o), 4);
    smp(3, -3);
    check("pick_novalid", int'(valid), 0);
    smp(4, -4);
    check("pick_v1", int'(valid), 1);
    check("pick_a0", ch0(), 4);
    check("pick_a1", ch1(), -4);
    smp(5, -5);
    check("pick_pulse", int'(valid), 0);
    smp(6, -6); smp(7, -7); smp(8, -8);
    check("pick_v2", int'(valid), 1);
    check("pick_b0", ch0(), 8);
    check("pick_b1", ch1(), -8);
    tick();
    check("pick_end", int'(valid), 0);

    // Accumulate mode, R=3
    mode = 1'b1; ratio = 8'd3;
    smp(10, 1); smp(-3, 2); smp(5, 3);
    check("acc_v1", int'(valid), 1);
    check("acc_a0", ch0(), 12);
    check("acc_a1", ch1(), 6);
    smp(32767, -32768); smp(32767, -32768); smp(32767, -32768);
    check("acc_b0", ch0(), 98301);
    check("acc_b1", ch1(), -98304);

    // Ratio 0 and 1 pass samples straight through
    mode = 1'b0; ratio = 8'd0;
    smp(7, 70);
    check("r0_ratio", int'(ratio_o), 1);
    check("r0_a", ch0(), 7);
    smp(9, 90);
    check("r0_v", int'(valid), 1);
    check("r0_b", ch1(), 90);
    ratio = 8'd1;
    smp(-11, 5);
    check("r1_a", ch0(), -11);
    check("r1_ovr", int'(ovr), 0);
    tick();

    // Backpressure, R=2
    ratio = 8'd2; ready = 1'b0;
    smp(1, 0); smp(2, 0);
    check("bp_v1", int'(valid), 1);
    check("bp_ovr0", int'(ovr), 0);
    smp(3, 0); smp(4, 0);
    check("bp_data", ch0(), 4);
    check("bp_ovr1", int'(ovr), 1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("bp_clr", int'(ovr), 0);
    check("bp_hold", int'(valid), 1);
    smp(5, 0);
    ready = 1'b1;
    smp(6, 0);
    check("bp_hs_ovr", int'(ovr), 0);
    check("bp_hs_v", int'(valid), 1);
    check("bp_hs_d", ch0(), 6);
    ready = 1'b0;
    smp(7, 0);
    clr_ovr = 1'b1;
    smp(8, 0);
    clr_ovr = 1'b0;
    check("bp_setwins", int'(ovr), 1);
    ready = 1'b1; clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("bp_drain", int'(valid), 0);

    // Mid-frame ratio change
    ratio = 8'd4;
    smp(1, 0); smp(2, 0);
    ratio = 8'd2;
    smp(3, 0);
    check("mid_nov", int'(valid), 0);
    smp(4, 0);
    check("mid_v", int'(valid), 1);
    check("mid_d", ch0(), 4);
    check("mid_r4", int'(ratio_o), 4);
    smp(5, 0);
    check("mid_r2", int'(ratio_o), 2);
    check("mid_nov2", int'(valid), 0);
    smp(6, 0);
    check("mid_d2", ch0(), 6);

    // Flush after 3 samples, flush beats a coincident sample
    ratio = 8'd4;
    smp(1, 0); smp(2, 0); smp(3, 0);
    flush = 1'b1; smp(99, 0); flush = 1'b0;
    check("fl_nov", int'(valid), 0);
    smp(10, 0); smp(11, 0); smp(12, 0);
    check("fl_nov2", int'(valid), 0);
    smp(13, 0);
    check("fl_v", int'(valid), 1);
    check("fl_d", ch0(), 13);

    // Async reset mid-frame in accumulate mode
    mode = 1'b1;
    smp(1, 0); smp(2, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_data", ch0(), 0);
    check("ar_valid", int'(valid), 0);
    check("ar_ratio", int'(ratio_o), 1);
    tick();
    rst_n = 1'b1;
    tick();
    smp(1, 0); smp(1, 0); smp(1, 0);
    check("ar_nov", int'(valid), 0);
    smp(1, 0);
    check("ar_v", int'(valid), 1);
    check("ar_d", ch0(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
